// File: rtl/codec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : codec_pkg
//  Description : Shared codec definitions: convolutional code generators,
//                trellis state type and encoder FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package codec_pkg;

    // Generator polynomials applied to {u, s1, s0}
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    // 4-state trellis state {s1, s0}, shared with the Viterbi decoder
    typedef logic [1:0] trellis_state_t;

    // Encoder control FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } enc_fsm_t;

endpackage : codec_pkg
`default_nettype wire

// File: rtl/conv_enc_core.sv
`default_nettype none
// ============================================================================
//  Module      : conv_enc_core
//  Description : Combinational K=3 rate-1/2 encoder step: input bit plus
//                trellis state to coded symbol and successor state. Also
//                usable as a branch-label reference for the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_enc_core
    import codec_pkg::*;
(
    input  logic           u,
    input  trellis_state_t state,
    output logic [1:0]     sym,
    output trellis_state_t next_state
);

    logic [2:0] w_reg;

    assign w_reg      = {u, state};
    // [1] is the G0 branch (u^s1^s0), [0] the G1 branch (u^s0)
    assign sym        = {^(w_reg & G0), ^(w_reg & G1)};
    assign next_state = {u, state[1]};

endmodule : conv_enc_core
`default_nettype wire

// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : conv_encoder
//  Description : Rate-1/2 K=3 convolutional encoder. Serialises DATA_W-bit
//                words MSB-first into 2-bit symbols with valid/ready
//                handshakes and an optional two-bit zero tail per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_encoder
    import codec_pkg::*;
#(
    parameter int DATA_W  = 8,      // must be >= 2
    parameter bit TAIL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              last_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [1:0]        sym_out,
    output logic              sym_valid,
    input  logic              sym_ready,
    output logic              sym_last,
    output logic [1:0]        enc_state,
    output logic              busy
);

    localparam int             CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_CNT_PEN  = CNT_W'(DATA_W - 2);

    enc_fsm_t          fsm_q, fsm_d;
    logic [DATA_W-1:0] data_q, data_d;          // bits still to be presented, next at MSB
    logic              last_q, last_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tail_cnt_q, tail_cnt_d;
    logic              in_frame_q, in_frame_d;
    trellis_state_t    enc_state_q, enc_state_d; // state before the presented bit
    trellis_state_t    post_state_q, post_state_d; // state after the presented bit
    logic [1:0]        sym_q, sym_d;
    logic              sym_valid_q, sym_valid_d;
    logic              sym_last_q, sym_last_d;

    logic              w_la_u;
    trellis_state_t    w_la_state;
    logic [1:0]        w_la_sym;
    trellis_state_t    w_la_next;
    logic              w_sym_hs;
    logic              w_last_bit;

    assign w_sym_hs   = sym_valid_q && sym_ready;
    assign w_last_bit = (bit_cnt_q == c_CNT_LAST);

    // Symbols are precomputed one handshake ahead so sym_out is a flop
    conv_enc_core u_core (
        .u          (w_la_u),
        .state      (w_la_state),
        .sym        (w_la_sym),
        .next_state (w_la_next)
    );

    // Select the bit and starting state of the symbol to be presented next
    always_comb begin
        w_la_u     = 1'b0;
        w_la_state = post_state_q;
        case (fsm_q)
            IDLE: begin
                w_la_u     = data_in[DATA_W-1];
                w_la_state = in_frame_q ? enc_state_q : 2'b00;
            end
            SHIFT: begin
                // at word end: reload from data_in, or a zero tail bit if last
                w_la_u = w_last_bit ? (!last_q && data_in[DATA_W-1]) : data_q[DATA_W-1];
            end
            default: begin
                w_la_u = 1'b0;
            end
        endcase
    end

    // Word acceptance; back-to-back reload depends combinationally on sym_ready
    always_comb begin
        ready_out = 1'b0;
        case (fsm_q)
            IDLE:    ready_out = 1'b1;
            SHIFT:   ready_out = w_last_bit && sym_ready && !last_q;
            default: ready_out = 1'b0;
        endcase
    end

    // Next-state logic; everything holds unless a handshake or acceptance occurs
    always_comb begin
        fsm_d        = fsm_q;
        data_d       = data_q;
        last_d       = last_q;
        bit_cnt_d    = bit_cnt_q;
        tail_cnt_d   = tail_cnt_q;
        in_frame_d   = in_frame_q;
        enc_state_d  = enc_state_q;
        post_state_d = post_state_q;
        sym_d        = sym_q;
        sym_valid_d  = sym_valid_q;
        sym_last_d   = sym_last_q;

        if (w_sym_hs && sym_last_q) begin
            in_frame_d = 1'b0;
        end

        case (fsm_q)
            IDLE: begin
                if (valid_in) begin
                    data_d       = {data_in[DATA_W-2:0], 1'b0};
                    last_d       = last_in;
                    bit_cnt_d    = '0;
                    enc_state_d  = w_la_state;
                    post_state_d = w_la_next;
                    sym_d        = w_la_sym;
                    sym_valid_d  = 1'b1;
                    sym_last_d   = 1'b0;
                    in_frame_d   = 1'b1;
                    fsm_d        = SHIFT;
                end
            end
            SHIFT: begin
                if (w_sym_hs) begin
                    enc_state_d = post_state_q;
                    if (w_last_bit) begin
                        if (last_q) begin
                            if (TAIL_EN) begin
                                fsm_d        = TAIL;
                                tail_cnt_d   = 1'b0;
                                sym_d        = w_la_sym;
                                post_state_d = w_la_next;
                                sym_last_d   = 1'b0;
                            end else begin
                                fsm_d       = IDLE;
                                sym_valid_d = 1'b0;
                                sym_last_d  = 1'b0;
                            end
                        end else if (valid_in) begin
                            data_d       = {data_in[DATA_W-2:0], 1'b0};
                            last_d       = last_in;
                            bit_cnt_d    = '0;
                            post_state_d = w_la_next;
                            sym_d        = w_la_sym;
                            sym_last_d   = 1'b0;
                        end else begin
                            fsm_d       = IDLE;
                            sym_valid_d = 1'b0;
                            sym_last_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d    = bit_cnt_q + CNT_W'(1);
                        data_d       = {data_q[DATA_W-2:0], 1'b0};
                        post_state_d = w_la_next;
                        sym_d        = w_la_sym;
                        sym_last_d   = !TAIL_EN && last_q && (bit_cnt_q == c_CNT_PEN);
                    end
                end
            end
            TAIL: begin
                if (w_sym_hs) begin
                    enc_state_d = post_state_q;
                    if (!tail_cnt_q) begin
                        tail_cnt_d   = 1'b1;
                        sym_d        = w_la_sym;
                        post_state_d = w_la_next;
                        sym_last_d   = 1'b1;
                    end else begin
                        fsm_d       = IDLE;
                        sym_valid_d = 1'b0;
                        sym_last_d  = 1'b0;
                    end
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any frame in progress without a tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            data_q       <= '0;
            last_q       <= 1'b0;
            bit_cnt_q    <= '0;
            tail_cnt_q   <= 1'b0;
            in_frame_q   <= 1'b0;
            enc_state_q  <= 2'b00;
            post_state_q <= 2'b00;
            sym_q        <= 2'b00;
            sym_valid_q  <= 1'b0;
            sym_last_q   <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            data_q       <= data_d;
            last_q       <= last_d;
            bit_cnt_q    <= bit_cnt_d;
            tail_cnt_q   <= tail_cnt_d;
            in_frame_q   <= in_frame_d;
            enc_state_q  <= enc_state_d;
            post_state_q <= post_state_d;
            sym_q        <= sym_d;
            sym_valid_q  <= sym_valid_d;
            sym_last_q   <= sym_last_d;
        end
    end

    assign sym_out   = sym_q;
    assign sym_valid = sym_valid_q;
    assign sym_last  = sym_last_q;
    assign enc_state = enc_state_q;
    assign busy      = (fsm_q != IDLE);

endmodule : conv_encoder
`default_nettype wire
